// File: rtl/comfort_pkg.sv
// Shared types and arithmetic helpers for the comfort ramp controller.
// Contents:
//   ch_state_t  - per-channel FSM state encoding (IDLE/RAMP/HOLD)
//   abs_diff    - unsigned |a-b| computed without wrap
//   step_toward - one saturating step of cur toward tgt, never overshooting
// Helpers work at MAX_W bits; callers zero-extend DW-bit values (DW <= 31).
package comfort_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } ch_state_t;

  // Larger minus smaller, so the result is always the true distance
  function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Upward sum kept one bit wider so cur+step cannot wrap before clamping
  function automatic logic [MAX_W-1:0] step_toward(input logic [MAX_W-1:0] cur,
                                                   input logic [MAX_W-1:0] tgt,
                                                   input logic [MAX_W-1:0] step);
    logic [MAX_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (cur < tgt)
      return (sum > {1'b0, tgt}) ? tgt : sum[MAX_W-1:0];
    else if (cur > tgt)
      return ((cur - tgt) <= step) ? tgt : (cur - step);
    else
      return cur;
  endfunction

endpackage

// File: rtl/comfort_ramp_ctrl_if.sv
// Bus bundle between the home-automation core and the comfort controller.
// Signals:
//   pass_check  - access-granted level enable
//   ideal_flat  - per-channel ideal values, channel k at [k*DW +: DW]
//   sens_flat   - per-channel sensor readings, same packing
//   set_flat    - per-channel registered setpoints, same packing
//   busy        - channel k is ramping
//   at_target   - channel k is holding
//   any_busy    - OR of busy
// Modports: master (core side), slave (controller side).
interface comfort_ramp_ctrl_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DW     = 8
);
  logic                   pass_check;
  logic [NUM_CH*DW-1:0]   ideal_flat;
  logic [NUM_CH*DW-1:0]   sens_flat;
  logic [NUM_CH*DW-1:0]   set_flat;
  logic [NUM_CH-1:0]      busy;
  logic [NUM_CH-1:0]      at_target;
  logic                   any_busy;

  modport master (
    output pass_check, ideal_flat, sens_flat,
    input  set_flat, busy, at_target, any_busy
  );

  modport slave (
    input  pass_check, ideal_flat, sens_flat,
    output set_flat, busy, at_target, any_busy
  );
endinterface

// File: rtl/comfort_ramp_ch.sv
// One comfort channel: IDLE/RAMP/HOLD FSM plus its setpoint register.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   tick         - shared prescaler step strobe
//   load         - pass_check rising edge: reload setpoint from sensor
//   enable       - pass_check level; low forces IDLE, setpoint kept
//   ideal, sens  - channel ideal value and sensor reading
//   o_set        - registered setpoint
//   o_busy       - registered, state is RAMP
//   o_at_target  - registered, state is HOLD
module comfort_ramp_ch
  import comfort_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned STEP_SIZE = 1,
  parameter int unsigned DEADBAND  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          load,
  input  logic          enable,
  input  logic [DW-1:0] ideal,
  input  logic [DW-1:0] sens,
  output logic [DW-1:0] o_set,
  output logic          o_busy,
  output logic          o_at_target
);

  ch_state_t        r_state;
  logic [DW-1:0]    r_set;
  logic             r_busy;
  logic             r_at_target;
  logic [DW-1:0]    w_step;
  logic [MAX_W-1:0] w_diff;

  // Clamped result always lies between set and ideal, so it fits in DW bits
  assign w_step = DW'(step_toward(MAX_W'(r_set), MAX_W'(ideal), MAX_W'(STEP_SIZE)));
  assign w_diff = abs_diff(MAX_W'(ideal), MAX_W'(r_set));

  // Channel FSM; busy/at_target are updated alongside the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_set       <= '0;
      r_busy      <= 1'b0;
      r_at_target <= 1'b0;
    end else if (!enable) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_at_target <= 1'b0;
    end else if (load) begin
      // Load takes priority over a coincident tick
      r_set <= sens;
      if (sens == ideal) begin
        r_state     <= HOLD;
        r_busy      <= 1'b0;
        r_at_target <= 1'b1;
      end else begin
        r_state     <= RAMP;
        r_busy      <= 1'b1;
        r_at_target <= 1'b0;
      end
    end else begin
      case (r_state)
        RAMP: begin
          if (tick) begin
            r_set <= w_step;
            if (w_step == ideal) begin
              r_state     <= HOLD;
              r_busy      <= 1'b0;
              r_at_target <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (w_diff > MAX_W'(DEADBAND)) begin
            r_state     <= RAMP;
            r_busy      <= 1'b1;
            r_at_target <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_set       = r_set;
  assign o_busy      = r_busy;
  assign o_at_target = r_at_target;

endmodule

// File: rtl/comfort_ramp_ctrl.sv
// Multi-channel comfort controller: ramps each setpoint toward its ideal
// value while access is granted, then holds within a deadband.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   bus        - comfort_ramp_ctrl_if.slave (pass_check, ideal/sens in,
//                set/busy/at_target/any_busy out)
module comfort_ramp_ctrl
  import comfort_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DW        = 8,
  parameter int unsigned STEP_DIV  = 10,
  parameter int unsigned STEP_SIZE = 1,
  parameter int unsigned DEADBAND  = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  comfort_ramp_ctrl_if.slave  bus
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic                 r_pass_q;
  logic [CW-1:0]        r_presc;
  logic                 w_rise;
  logic                 w_tick;
  logic [NUM_CH*DW-1:0] w_set;
  logic [NUM_CH-1:0]    w_busy;
  logic [NUM_CH-1:0]    w_at_target;

  assign w_rise = bus.pass_check & ~r_pass_q;
  assign w_tick = (r_presc == CW'(STEP_DIV - 1));

  // Edge detect and shared prescaler; cleared while disabled and on the load cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_q <= 1'b0;
      r_presc  <= '0;
    end else begin
      r_pass_q <= bus.pass_check;
      if (!bus.pass_check || w_rise || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + CW'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    comfort_ramp_ch #(
      .DW        (DW),
      .STEP_SIZE (STEP_SIZE),
      .DEADBAND  (DEADBAND)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (w_tick),
      .load        (w_rise),
      .enable      (bus.pass_check),
      .ideal       (bus.ideal_flat[k*DW +: DW]),
      .sens        (bus.sens_flat[k*DW +: DW]),
      .o_set       (w_set[k*DW +: DW]),
      .o_busy      (w_busy[k]),
      .o_at_target (w_at_target[k])
    );
  end

  assign bus.set_flat  = w_set;
  assign bus.busy      = w_busy;
  assign bus.at_target = w_at_target;
  assign bus.any_busy  = |w_busy;

endmodule

// File: doc/comfort_ramp_ctrl.md
Name: comfort_ramp_ctrl

Overview:
- Multi-channel comfort controller for the home-automation core. Each channel covers one quantity: temperature, light level, humidity and so on.
- While access is granted (pass_check=1), each channel's setpoint output ramps toward the channel's ideal value in fixed steps at a programmable rate.
- Ramping runs in both directions and never overshoots.
- A per-channel deadband prevents hunting once a channel has reached its target.
- Successor to the single-shot temperature/light comfort logic: clocked, N channels, bidirectional, with status outputs.

Parameters:
- NUM_CH, 2: number of independent channels (1..16).
- DW, 8: width of each ideal, sensor and setpoint value (unsigned).
- STEP_DIV, 10: clock cycles per ramp step (>=1).
- STEP_SIZE, 1: setpoint increment or decrement per step (1..2^DW-1).
- DEADBAND, 0: in HOLD, the allowed |ideal-set| before ramping restarts.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- pass_check, input, 1: access-granted enable from the security block; level sensitive.
- ideal_flat, input, NUM_CH*DW: ideal values; channel k occupies [k*DW +: DW].
- sens_flat, input, NUM_CH*DW: current sensor readings, same packing.
- set_flat, output, NUM_CH*DW: registered setpoints, same packing.
- busy, output, NUM_CH: channel k is in RAMP.
- at_target, output, NUM_CH: channel k is in HOLD.
- any_busy, output, 1: OR of busy.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: set_flat=0, busy=0, at_target=0, any_busy=0. Prescaler=0, pass_q=0, all channels in IDLE.
- Reset asserted mid-ramp clears everything immediately, asynchronously.
- pass_q is the registered copy of pass_check. A rising edge is detected as pass_check=1 and pass_q=0.
- Prescaler (shared by all channels):
  - Counts 0..STEP_DIV-1 while pass_check=1.
  - Forced to 0 on the rising-edge cycle and whenever pass_check=0.
  - tick=1 when the count equals STEP_DIV-1; the count wraps to 0 on the same edge.
  - With STEP_DIV=1, tick=1 on every cycle after the rising-edge cycle.
- Per-channel FSM, states IDLE, RAMP, HOLD:
  - IDLE:
    - set holds its last value.
    - On a rising edge: set<=sens[k]. Next state is HOLD if sens[k]==ideal[k], otherwise RAMP.
  - RAMP:
    - On tick, if set<ideal: set<=min(set+STEP_SIZE, ideal).
    - On tick, if set>ideal: set<=max(set-STEP_SIZE, ideal).
    - When the updated set equals ideal, the next state is HOLD.
    - The ideal value is re-sampled every tick. A change in ideal mid-ramp reverses direction if needed, with no extra latency.
  - HOLD:
    - set is frozen.
    - When |ideal-set|>DEADBAND: next state is RAMP. The first step occurs on the next tick.
  - Any state: pass_check=0 forces the next state to IDLE; set keeps its value.
  - When pass_check=1 and pass_q=1, nothing re-loads from sensors.
- Step latency: the first step lands STEP_DIV cycles after the rising-edge cycle, then one step every STEP_DIV cycles.
- Arithmetic:
  - Computed at DW+1 bits so that set+STEP_SIZE cannot wrap. Clamping makes the result fit in DW bits.
  - |ideal-set| is computed unsigned at DW bits by subtracting the smaller from the larger.
- Outputs:
  - busy[k] = (state==RAMP).
  - at_target[k] = (state==HOLD).
  - Both are decoded from registered state, with no combinational path from inputs.
- Simultaneous events:
  - A rising edge coinciding with a tick: the load wins and the prescaler clears.
  - pass_check falling in the same cycle as a tick: no step; the channel goes to IDLE.

Decomposition:
- Package comfort_pkg holds:
  - the state encoding (IDLE=2'd0, RAMP=2'd1, HOLD=2'd2);
  - the abs-difference and saturating-step functions.
- One sub-module, comfort_ramp_ch, holds one channel's FSM and setpoint register.
  - Inputs: clk, rst_n, tick, load, enable, ideal, sens.
  - Generated NUM_CH times.
- The prescaler and edge detect live in the top level.

Test Plan:
- Test configuration for all scenarios: NUM_CH=2, DW=8, STEP_DIV=4, STEP_SIZE=1, DEADBAND=0.
- Ramp up and down:
  - Stimulus: ch0 sens=20, ideal=23; ch1 sens=50, ideal=48; raise pass_check.
  - Response: set0=20 and set1=50 one cycle after the rising edge.
  - set0 steps 21,22,23 every 4 cycles, then at_target0=1.
  - set1 steps 49,48, then HOLD; any_busy falls after the last step.
- No overshoot:
  - Stimulus: STEP_SIZE=5, sens=10, ideal=22.
  - Response: set sequence 10,15,20,22, then HOLD.
- Saturation:
  - Stimulus: DW=8, STEP_SIZE=200, sens=100, ideal=255.
  - Response: set goes 100 to 255 in one step; no wrap to 44.
- Deadband:
  - Stimulus: DEADBAND=2; in HOLD at set=30, ideal changes to 32, then to 33.
  - Response: at 32, state stays HOLD and set stays 30.
  - At 33, RAMP starts; set steps 31,32,33.
- pass_check drop:
  - Stimulus: pass_check goes low mid-ramp at set=22 (target 25).
  - Response: set holds 22 and busy=0.
  - On re-assert with sens=18, set reloads to 18 and ramps to 25.
- Asynchronous reset:
  - Stimulus: assert rst_n=0 between clock edges mid-ramp.
  - Response: set_flat, busy and at_target go to 0 immediately, without a clock edge.
  - After release, nothing happens until a new pass_check rising edge.
